// File: rtl/shacc_pkg.sv
// shacc_pkg: shared op encoding, saturation bounds and lane slicing for shacc_vec.
package shacc_pkg;
    typedef enum logic [1:0] {OP_LD, OP_ACC, OP_SHACC} op_e;
    function automatic longint smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
    function automatic longint smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction
endpackage

// File: rtl/shacc_lane.sv
// shacc_lane: one shift-accumulator lane with sticky overflow, sat/wrap and output register.
module shacc_lane
    import shacc_pkg::*;
#(
    parameter int a   = 8,
    parameter int w   = 32,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         valid,
    input  op_e          op,
    input  logic         neg,
    input  logic         last,
    input  logic [a-1:0] data,
    output logic [w-1:0] odata,
    output logic         ovf
);
    localparam logic signed [w+1:0] MAX = (w+2)'(smax(w));
    localparam logic signed [w+1:0] MIN = (w+2)'(smin(w));
    logic [w-1:0] acc, nxt;
    logic signed [w+1:0] ext, t, base, raw;
    logic sticky, sticky_nxt, hi, lo;
    always_comb begin
        ext        = {{(w+2-a){data[a-1]}}, data};
        t          = neg ? -ext : ext;
        base       = op == OP_LD ? '0 : op == OP_SHACC ? {acc[w-1], acc, 1'b0} : {{2{acc[w-1]}}, acc};
        raw        = base + t;
        hi         = raw > MAX;
        lo         = raw < MIN;
        nxt        = (SAT != 0 && hi) ? MAX[w-1:0] : (SAT != 0 && lo) ? MIN[w-1:0] : raw[w-1:0];
        sticky_nxt = (op == OP_LD ? 1'b0 : sticky) | hi | lo;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            acc    <= '0;
            sticky <= 1'b0;
            odata  <= '0;
            ovf    <= 1'b0;
        end else if (valid) begin
            acc    <= nxt;
            sticky <= sticky_nxt;
            if (last) begin
                odata <= nxt;
                ovf   <= sticky_nxt;
            end
        end
    end
endmodule

// File: rtl/shacc_vec.sv
// shacc_vec: N-lane signed shifter-accumulator for the bit-serial MVU datapath.
module shacc_vec
    import shacc_pkg::*;
#(
    parameter int N   = 4,
    parameter int a   = 8,
    parameter int w   = 32,
    parameter int SAT = 0
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           i_valid,
    input  logic           i_ld,
    input  logic           i_sh,
    input  logic           i_neg,
    input  logic           i_last,
    input  logic [N*a-1:0] i_data,
    output logic           o_valid,
    output logic [N*w-1:0] o_data,
    output logic [N-1:0]   o_ovf
);
    op_e op;
    always_comb op = i_ld ? OP_LD : i_sh ? OP_SHACC : OP_ACC;
    for (genvar k = 0; k < N; k++) begin : g_lane
        shacc_lane #(.a(a), .w(w), .SAT(SAT)) u_lane (
            .clk   (clk),
            .clr   (clr),
            .valid (i_valid),
            .op    (op),
            .neg   (i_neg),
            .last  (i_last),
            .data  (i_data[lane_lsb(k, a) +: a]),
            .odata (o_data[lane_lsb(k, w) +: w]),
            .ovf   (o_ovf[k])
        );
    end
    always_ff @(posedge clk) o_valid <= clr ? 1'b0 : i_valid & i_last;
endmodule

// File: tb/tb_shacc_vec.sv
// tb_shacc_vec: directed checks of shacc_vec in wrap (w=32, w=8) and saturating (w=8) builds.
module tb_shacc_vec;
    logic clk = 1'b0;
    logic clr, vld, ld, sh, neg, last;
    logic [15:0] d0;
    logic [7:0] d1;
    logic u0_valid, u1_valid, u2_valid;
    logic [63:0] u0_data;
    logic [7:0] u1_data, u2_data;
    logic [1:0] u0_ovf;
    logic [0:0] u1_ovf, u2_ovf;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    shacc_vec #(.N(2), .a(8), .w(32), .SAT(0)) u0 (
        .clk(clk), .clr(clr), .i_valid(vld), .i_ld(ld), .i_sh(sh), .i_neg(neg), .i_last(last),
        .i_data(d0), .o_valid(u0_valid), .o_data(u0_data), .o_ovf(u0_ovf));
    shacc_vec #(.N(1), .a(8), .w(8), .SAT(1)) u1 (
        .clk(clk), .clr(clr), .i_valid(vld), .i_ld(ld), .i_sh(sh), .i_neg(neg), .i_last(last),
        .i_data(d1), .o_valid(u1_valid), .o_data(u1_data), .o_ovf(u1_ovf));
    shacc_vec #(.N(1), .a(8), .w(8), .SAT(0)) u2 (
        .clk(clk), .clr(clr), .i_valid(vld), .i_ld(ld), .i_sh(sh), .i_neg(neg), .i_last(last),
        .i_data(d1), .o_valid(u2_valid), .o_data(u2_data), .o_ovf(u2_ovf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // drive one cycle from a falling edge; returns at the next falling edge
    task automatic beat(input logic v, input logic l, input logic s, input logic n, input logic t,
                        input logic [15:0] x0, input logic [7:0] x1);
        vld = v; ld = l; sh = s; neg = n; last = t; d0 = x0; d1 = x1;
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1; vld = 1'b0; ld = 1'b0; sh = 1'b0; neg = 1'b0; last = 1'b0; d0 = '0; d1 = '0;
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        check("rst_valid", 32'(u0_valid), 32'd0);
        check("rst_data0", u0_data[31:0], 32'd0);
        check("rst_data1", u0_data[63:32], 32'd0);
        check("rst_ovf", 32'(u0_ovf), 32'd0);

        beat(1, 1, 0, 0, 0, {8'd2, 8'd1}, 8'd0);
        check("a_mid1_valid", 32'(u0_valid), 32'd0);
        beat(1, 0, 1, 0, 0, {8'd1, 8'd0}, 8'd0);
        check("a_mid2_valid", 32'(u0_valid), 32'd0);
        beat(1, 0, 1, 0, 1, {8'd0, 8'd1}, 8'd0);
        check("a_valid", 32'(u0_valid), 32'd1);
        check("a_lane0", u0_data[31:0], 32'd5);
        check("a_lane1", u0_data[63:32], 32'd10);
        check("a_ovf", 32'(u0_ovf), 32'd0);

        beat(1, 1, 0, 1, 0, {8'd3, 8'd0}, 8'd0);
        check("b_mid_valid", 32'(u0_valid), 32'd0);
        beat(1, 0, 1, 0, 1, {8'd1, 8'd2}, 8'd0);
        check("b_valid", 32'(u0_valid), 32'd1);
        check("b_lane0", u0_data[31:0], 32'd2);
        check("b_lane1", u0_data[63:32], 32'hFFFF_FFFB);
        beat(1, 1, 0, 0, 1, {8'h80, 8'd5}, 8'd0);
        check("c_valid", 32'(u0_valid), 32'd1);
        check("c_lane0", u0_data[31:0], 32'd5);
        check("c_lane1", u0_data[63:32], 32'hFFFF_FF80);
        beat(0, 0, 0, 0, 0, 16'd0, 8'd0);
        check("c_pulse_end", 32'(u0_valid), 32'd0);
        check("c_hold", u0_data[63:32], 32'hFFFF_FF80);

        beat(1, 1, 0, 0, 0, 16'd0, 8'd100);
        beat(1, 0, 1, 0, 1, 16'd0, 8'd100);
        check("sat_pos", 32'(u1_data), 32'h7F);
        check("sat_pos_ovf", 32'(u1_ovf), 32'd1);
        check("wrap_pos", 32'(u2_data), 32'd44);
        check("wrap_pos_ovf", 32'(u2_ovf), 32'd1);
        check("wrap_valid", 32'(u2_valid), 32'd1);
        beat(1, 1, 0, 1, 0, 16'd0, 8'd100);
        beat(1, 0, 1, 1, 1, 16'd0, 8'd100);
        check("sat_neg", 32'(u1_data), 32'h80);
        check("sat_neg_ovf", 32'(u1_ovf), 32'd1);
        check("wrap_neg", 32'(u2_data), 32'hD4);
        beat(1, 1, 0, 0, 0, 16'd0, 8'd100);
        beat(1, 0, 1, 0, 0, 16'd0, 8'd100);
        beat(1, 0, 0, 0, 1, 16'd0, 8'd0);
        check("sticky_sat", 32'(u1_data), 32'h7F);
        check("sticky_sat_ovf", 32'(u1_ovf), 32'd1);
        check("sticky_wrap", 32'(u2_data), 32'd44);
        check("sticky_wrap_ovf", 32'(u2_ovf), 32'd1);
        beat(1, 1, 0, 0, 1, 16'd0, 8'd1);
        check("reld_sat", 32'(u1_data), 32'd1);
        check("reld_sat_ovf", 32'(u1_ovf), 32'd0);
        check("reld_wrap", 32'(u2_data), 32'd1);
        check("reld_wrap_ovf", 32'(u2_ovf), 32'd0);

        beat(1, 1, 0, 0, 0, {8'd0, 8'd3}, 8'd0);
        beat(1, 0, 0, 0, 0, {8'd0, 8'd4}, 8'd0);
        clr = 1'b1;
        beat(1, 0, 0, 0, 1, {8'd0, 8'd9}, 8'd0);
        clr = 1'b0;
        check("clr_valid", 32'(u0_valid), 32'd0);
        check("clr_data0", u0_data[31:0], 32'd0);
        check("clr_data1", u0_data[63:32], 32'd0);
        beat(1, 0, 0, 0, 1, {8'd0, 8'd7}, 8'd0);
        check("post_clr_valid", 32'(u0_valid), 32'd1);
        check("post_clr", u0_data[31:0], 32'd7);
        beat(1, 0, 0, 0, 1, {8'd0, 8'd1}, 8'd0);
        check("chain", u0_data[31:0], 32'd8);

        beat(1, 1, 0, 0, 0, {8'd0, 8'd2}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 1, 1, 1, {8'd0, 8'd50}, 8'd0);
            check("gap1_valid", 32'(u0_valid), 32'd0);
        end
        beat(1, 0, 0, 0, 0, {8'd0, 8'd3}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 1, 1, 1, {8'd0, 8'd50}, 8'd0);
            check("gap2_valid", 32'(u0_valid), 32'd0);
        end
        beat(1, 0, 0, 0, 1, {8'd0, 8'd4}, 8'd0);
        check("gap_valid", 32'(u0_valid), 32'd1);
        check("gap_sum", u0_data[31:0], 32'd9);
        beat(0, 0, 0, 0, 0, 16'd0, 8'd0);
        check("gap_single_pulse", 32'(u0_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
